// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store controller.
// Holds the access-size and FSM encodings, the latched request payload,
// and the byte-enable / store-replication / load-extension functions.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic              we;
        size_e             size;
        logic              is_uns;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Byte-lane enables for a store of the given size at the given lane.
    function automatic logic [BE_W-1:0] be_gen(input size_e size, input logic [1:0] lane);
        logic [BE_W-1:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = 4'b0011 << {lane[1], 1'b0};
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied onto every lane it could land in.
    function automatic logic [DATA_W-1:0] wdata_rep(input size_e size, input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] rep;
        case (size)
            SZ_B:    rep = {4{wdata[7:0]}};
            SZ_H:    rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Lane select plus sign/zero extension of a loaded word.
    function automatic logic [DATA_W-1:0] ld_extend(input logic [DATA_W-1:0] word, input size_e size,
                                                    input logic [1:0] lane, input logic is_uns);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = is_uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    r = is_uns ? {16'h0, h} : {{16{h[15]}}, h};
            SZ_W:    r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-organised data array: DEPTH x 32, synchronous read, per-byte write enable.
// Contents are not reset; the read register only updates when re is high.
// Ports: clk, re (read strobe), we (byte enables), addr (word index),
//        wdata (lane-replicated store data), rdata (registered read word).
module dmem_bram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [BE_W-1:0]   we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane writes and registered read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Data-memory load/store controller with valid/ready request and response.
// One request outstanding; programmable wait states; byte-accurate stores,
// sign/zero-extended loads, error response for misaligned, out-of-range or
// reserved-size accesses (no array write on error).
// Ports: clk, rst_n (async active-low),
//        req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata,
//        rsp_valid/rsp_ready, rsp_rdata, rsp_err.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              lat_q, lat_d;
    req_t              live, cur;
    logic              rsp_ld_q, rsp_ld_d;
    logic              req_ready_d, rsp_valid_d, rsp_err_d;
    logic              enter_resp;
    logic              cur_err, mis, rsv;
    logic [DATA_W-1:0] cur_off;
    logic              arr_re;
    logic [BE_W-1:0]   arr_we;
    logic [AW-1:0]     arr_idx;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign live = '{we: req_we, size: size_e'(req_size), is_uns: req_unsigned,
                    addr: req_addr, wdata: req_wdata};

    // In IDLE the live request is the one being decided on (zero-wait stores
    // write on the acceptance edge); afterwards only the latched copy counts.
    assign cur       = (state_q == IDLE) ? live : lat_q;
    assign cur_off   = cur.addr - BASE_ADDR;
    assign arr_idx   = AW'(cur_off >> 2);
    assign arr_wdata = wdata_rep(cur.size, cur.wdata);

    // Access legality; the offset wraps for addresses below BASE_ADDR.
    always_comb begin
        mis = 1'b0;
        rsv = 1'b0;
        case (cur.size)
            SZ_H:    mis = cur.addr[0];
            SZ_W:    mis = |cur.addr[1:0];
            SZ_RSV:  rsv = 1'b1;
            default: mis = 1'b0;
        endcase
        cur_err = mis | rsv | (cur_off >= SPAN);
    end

    // Next-state, array strobes and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        enter_resp = 1'b0;
        arr_re     = 1'b0;
        arr_we     = '0;
        rsp_err_d  = rsp_err;
        rsp_ld_d   = rsp_ld_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_d  = live;
                    arr_re = !req_we;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            if (cur.we && !cur_err) begin
                arr_we = be_gen(cur.size, cur.addr[1:0]);
            end
            rsp_err_d = cur_err;
            rsp_ld_d  = !cur.we && !cur_err;
        end else if (state_d != RESP) begin
            rsp_err_d = 1'b0;
            rsp_ld_d  = 1'b0;
        end

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            rsp_ld_q  <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            rsp_ld_q  <= rsp_ld_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // The array's read register is the load pipeline stage; lane select and
    // extension follow it so zero-wait loads respond one cycle after acceptance.
    // The read register is only reloaded in IDLE, so data holds through RESP.
    assign rsp_rdata = rsp_ld_q ? ld_extend(arr_rdata, lat_q.size, lat_q.addr[1:0], lat_q.is_uns)
                                : '0;

    dmem_bram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bram (
        .clk   (clk),
        .re    (arr_re),
        .we    (arr_we),
        .addr  (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench: one zero-wait and one three-wait instance share request
// fields; sel routes the handshake and the observed response to one of them.
module tb_dmem_lsu_ctrl;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, rsp_ready = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;

    logic        rdy0, rdy3, rv0, rv3, er0, er3;
    logic [31:0] rd0, rd3;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign req_ready = sel ? rdy3 : rdy0;
    assign rsp_valid = sel ? rv3  : rv0;
    assign rsp_err   = sel ? er3  : er0;
    assign rsp_rdata = sel ? rd3  : rd0;

    dmem_lsu_ctrl #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rd0), .rsp_err(er0)
    );

    dmem_lsu_ctrl #(.DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rd3), .rsp_err(er3)
    );

    // One transaction: request, scramble inputs while busy, wait (bounded),
    // optionally hold rsp_ready low, then accept the response.
    task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic stable, output logic ready_after);
        @(posedge clk); #1;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        req_valid = 1'b0; req_we = ~we; req_size = R; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFF1; req_wdata = 32'h5A5A_5A5A;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_rdata !== rdata || rsp_err !== err || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ready_after = req_ready;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d] got %b want 1", s, req_ready); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d] got %b want 0", s, rsp_valid); end
            n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d] got %h want 0", s, rsp_rdata); end
            n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d] got %b want 0", s, rsp_err); end
        end
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_word_byte_half();
        vec_t tv [13];
        logic [31:0] rd; logic er, st, ra; int lat;
        sel = 1'b0;
        tv[0]  = {1'b1, W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tv[1]  = {1'b0, W, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tv[2]  = {1'b1, B, 1'b0, 32'h13, 32'h1234_5680, 32'h0,         1'b0};
        tv[3]  = {1'b0, B, 1'b0, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0};
        tv[4]  = {1'b0, B, 1'b1, 32'h13, 32'h0,         32'h0000_0080, 1'b0};
        tv[5]  = {1'b0, W, 1'b0, 32'h10, 32'h0,         32'h80AD_BEEF, 1'b0};
        tv[6]  = {1'b1, W, 1'b0, 32'h10, 32'h8001_7FFF, 32'h0,         1'b0};
        tv[7]  = {1'b0, H, 1'b0, 32'h12, 32'h0,         32'hFFFF_8001, 1'b0};
        tv[8]  = {1'b0, H, 1'b1, 32'h12, 32'h0,         32'h0000_8001, 1'b0};
        tv[9]  = {1'b0, H, 1'b0, 32'h11, 32'h0,         32'h0,         1'b1};
        tv[10] = {1'b0, H, 1'b0, 32'h10, 32'h0,         32'h0000_7FFF, 1'b0};
        tv[11] = {1'b1, H, 1'b0, 32'h12, 32'h0000_ABCD, 32'h0,         1'b0};
        tv[12] = {1'b0, W, 1'b0, 32'h10, 32'h0,         32'hABCD_7FFF, 1'b0};
        for (int i = 0; i < 13; i++) begin
            xfer(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 0, rd, er, lat, st, ra);
            n_cmp++; if (rd !== tv[i].exp_rd) begin n_bad++; $display("FAIL lsu[%0d] rdata got %h want %h", i, rd, tv[i].exp_rd); end
            n_cmp++; if (er !== tv[i].exp_err) begin n_bad++; $display("FAIL lsu[%0d] err got %b want %b", i, er, tv[i].exp_err); end
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lsu[%0d] latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_errors();
        vec_t tv [9];
        logic [31:0] rd; logic er, st, ra; int lat;
        sel = 1'b0;
        tv[0] = {1'b1, W, 1'b0, 32'h0,         32'h1122_3344, 32'h0,         1'b0};
        tv[1] = {1'b1, W, 1'b0, 32'h1000,      32'hAAAA_AAAA, 32'h0,         1'b1};
        tv[2] = {1'b1, W, 1'b0, 32'h2,         32'hBBBB_BBBB, 32'h0,         1'b1};
        tv[3] = {1'b1, R, 1'b0, 32'h0,         32'hCCCC_CCCC, 32'h0,         1'b1};
        tv[4] = {1'b0, W, 1'b0, 32'h0,         32'h0,         32'h1122_3344, 1'b0};
        tv[5] = {1'b0, W, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
        tv[6] = {1'b1, W, 1'b0, 32'hFFC,       32'h0102_0304, 32'h0,         1'b0};
        tv[7] = {1'b0, B, 1'b0, 32'hFFF,       32'h0,         32'h0000_0001, 1'b0};
        tv[8] = {1'b0, W, 1'b0, 32'h1000,      32'h0,         32'h0,         1'b1};
        for (int i = 0; i < 9; i++) begin
            xfer(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 0, rd, er, lat, st, ra);
            n_cmp++; if (rd !== tv[i].exp_rd) begin n_bad++; $display("FAIL err[%0d] rdata got %h want %h", i, rd, tv[i].exp_rd); end
            n_cmp++; if (er !== tv[i].exp_err) begin n_bad++; $display("FAIL err[%0d] err got %b want %b", i, er, tv[i].exp_err); end
        end
    endtask

    task automatic test_wait_hold();
        logic [31:0] rd; logic er, st, ra; int lat;
        sel = 1'b1;
        xfer(1'b1, W, 1'b0, 32'h20, 32'hCAFE_F00D, 0, rd, er, lat, st, ra);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_store latency got %0d want 4", lat); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ws3_store err got %b want 0", er); end
        xfer(1'b0, W, 1'b0, 32'h20, 32'h0, 5, rd, er, lat, st, ra);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ws3_load latency got %0d want 4", lat); end
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ws3_load rdata got %h want cafef00d", rd); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL ws3_hold_stable got %b want 1", st); end
        n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL ws3_ready_after got %b want 1", ra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, st, ra; int lat;
        sel = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b1; req_size = W; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy ready got %b want 0", req_ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset valid got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset ready got %b want 1", req_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(1'b0, W, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, st, ra);
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mid_reload rdata got %h want cafef00d", rd); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL mid_reload latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_word_byte_half();
        test_errors();
        test_wait_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
